// File: rtl/mul_acc_unit_if.sv
// mul_acc_unit_if: execute-stage start/ready handshake bundle for the multiply-accumulate unit
interface mul_acc_unit_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [1:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] acc_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;
  modport master (
    output start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i, acc_i,
    input  result_o, ready_o, busy_o
  );
  modport slave (
    input  start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i, acc_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/mul_acc_unit.sv
// mul_acc_unit: iterative shift-add multiply with optional accumulate/subtract into HI/LO
module mul_acc_unit #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul_acc_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic            r_neg;
  logic [W2-1:0]   r_acc, r_prod, r_mcand, r_result;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  logic [W2-1:0]   w_p, w_r;
  logic            w_cap, w_zero, w_last, w_ready, w_busy;
  assign w_cap  = bus.start_i && !bus.annul_i;
  assign w_zero = EARLY_ZERO && (bus.opdata1_i == '0 || bus.opdata2_i == '0);
  assign w_last = r_cnt == LAST;
  assign w_mag1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_mag2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
  assign w_p    = r_neg ? ~r_prod + 1'b1 : r_prod;
  assign w_r    = (r_op == 2'b01) ? r_acc + w_p : (r_op == 2'b10) ? r_acc - w_p : w_p;
  assign bus.result_o = r_result;
  assign bus.ready_o  = w_ready;
  assign bus.busy_o   = w_busy;
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next-state and handshake outputs; annul pulls any active operation back to idle
  always_comb begin
    w_next  = r_state;
    w_busy  = r_state != IDLE;
    w_ready = r_state == DONE;
    case (r_state)
      IDLE:    w_next = w_cap ? (w_zero ? ACC : CALC) : IDLE;
      CALC:    w_next = bus.annul_i ? IDLE : (w_last ? ACC : CALC);
      ACC:     w_next = bus.annul_i ? IDLE : DONE;
      default: w_next = (bus.annul_i || !bus.start_i) ? IDLE : DONE;
    endcase
  end
  // datapath: capture magnitudes, shift-add one multiplier bit per cycle, then sign-fix and accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
    end else if (r_state != IDLE && bus.annul_i) begin
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_cap) begin
          r_op     <= bus.op_i;
          r_neg    <= bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          r_acc    <= bus.acc_i;
          r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
          r_mplier <= w_mag2;
          r_cnt    <= '0;
          r_prod   <= '0;
        end
        CALC: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        ACC:     r_result <= w_r;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_acc_unit.sv
// tb_mul_acc_unit: scoreboard bench for mul_acc_unit at WIDTH=32 with early-zero skip
module tb_mul_acc_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];
  mul_acc_unit_if #(.WIDTH(W)) bus ();
  mul_acc_unit #(.WIDTH(W), .EARLY_ZERO(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic sgn, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    logic [63:0] p;
    p = sgn ? ({{32{a[31]}}, a} * {{32{b[31]}}, b}) : ({32'b0, a} * {32'b0, b});
    return (op == 2'b01) ? acc + p : (op == 2'b10) ? acc - p : p;
  endfunction
  task automatic drive(input logic sgn, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] acc);
    bus.signed_i  = sgn;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.acc_i     = acc;
    bus.start_i   = 1'b1;
  endtask
  task automatic run_op(input logic sgn, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input logic [63:0] exp,
                        input int hold, input bit drop_early);
    int cyc;
    int lat;
    logic [63:0] e;
    lat = (a == 0 || b == 0) ? 2 : W + 2;
    sb.push_back(exp);
    @(negedge clk);
    drive(sgn, op, a, b, acc);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_after_capture", bus.busy_o, 1);
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.acc_i     = {$urandom, $urandom};
        bus.op_i      = 2'($urandom);
        bus.signed_i  = 1'($urandom);
        if (drop_early) bus.start_i = 1'b0;
      end
    end while (!bus.ready_o && cyc < 100);
    check("latency", 64'(cyc), 64'(lat));
    e = sb.pop_front();
    check("result", bus.result_o, e);
    if (!drop_early)
      repeat (hold) begin
        @(negedge clk);
        check("hold_ready", bus.ready_o, 1);
        check("hold_result", bus.result_o, e);
      end
    bus.start_i = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.ready_o, 0);
    check("idle_busy", bus.busy_o, 0);
    check("keep_result", bus.result_o, e);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [63:0] acc;
    logic [1:0] op;
    logic sgn;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_result", bus.result_o, 0);
    check("rst_ready", bus.ready_o, 0);
    check("rst_busy", bus.busy_o, 0);
    run_op(1'b1, 2'b00, -32'sd3, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 5, 1'b0);
    run_op(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 64'hFFFFFFFE_00000002, 0, 1'b0);
    run_op(1'b1, 2'b10, 32'd2, 32'd3, 64'd10, 64'd4, 1, 1'b0);
    run_op(1'b1, 2'b10, 32'h80000000, 32'h80000000, 64'd0, 64'hC0000000_00000000, 0, 1'b0);
    run_op(1'b0, 2'b01, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 0, 1'b0);
    run_op(1'b0, 2'b01, 32'd0, 32'h1234, 64'd7, 64'd7, 1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd9, 32'd9, 64'd0);
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_idle_busy", bus.busy_o, 0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd100, 32'd200, 64'd0);
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_busy", bus.busy_o, 0);
    check("annul_ready", bus.ready_o, 0);
    check("annul_result", bus.result_o, 0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    run_op(1'b0, 2'b00, 32'd6, 32'd7, 64'd0, 64'd42, 0, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd11, 32'd13, 64'd0);
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_result", bus.result_o, 0);
    check("midrst_ready", bus.ready_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    run_op(1'b1, 2'b01, -32'sd7, 32'd9, 64'd100, model(1'b1, 2'b01, -32'sd7, 32'd9, 64'd100), 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b   = $urandom;
      acc = {$urandom, $urandom};
      op  = 2'($urandom);
      sgn = 1'($urandom);
      run_op(sgn, op, a, b, acc, model(sgn, op, a, b, acc), i % 3, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_acc_unit.md
Name: mul_acc_unit

Overview:
- Multi-cycle, parametrised multiply / multiply-accumulate / multiply-subtract unit for the execute stage.
- Replaces the combinational-multiply-plus-two-cycle accumulate path.
- Execute stage drives it with a start/ready handshake, in the same way it drives the divider, and stalls the pipeline while the unit is busy.
- Computes signed or unsigned WIDTH x WIDTH products and optionally adds them to, or subtracts them from, a forwarded 2*WIDTH accumulator (HI/LO).

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 4. The result is 2*WIDTH bits.
- EARLY_ZERO, 1, when set to 1 a zero operand skips the iterative phase.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  request. Held high by the execute stage until ready_o is seen.
- annul_i  in  1  cancel the in-flight operation (flush or exception)
- signed_i  in  1  1 = signed operands, 0 = unsigned
- op_i  in  2  00 = MUL, 01 = MADD, 10 = MSUB, 11 = reserved (treated as MUL)
- opdata1_i  in  WIDTH  multiplicand
- opdata2_i  in  WIDTH  multiplier
- acc_i  in  2*WIDTH  accumulator {HI,LO}. Already forwarded from mem/wb.
- result_o  out  2*WIDTH  final result
- ready_o  out  1  result valid
- busy_o  out  1  unit occupied. Used by the execute stage as its stall request.

Behaviour:
- Reset (rst=1 at a clk edge, in any state):
  - state goes to IDLE
  - result_o = 0, ready_o = 0, busy_o = 0
  - all internal registers are cleared
  - reset wins over every other input, including during an operation
- States: IDLE, CALC, ACC, DONE.
- IDLE:
  - Transition to CALC when start_i=1 and annul_i=0.
  - Captured on that edge: op, a flag neg = signed_i & (opdata1_i[W-1] ^ opdata2_i[W-1]), and acc_i.
  - Operand magnitudes: when signed_i=1, each negative operand is stored as its two's complement; otherwise the raw value is stored.
  - Counter cnt = 0, partial product = 0.
  - If EARLY_ZERO=1 and either operand is 0, go straight to ACC with a product of 0 instead of CALC.
  - busy_o = 1 from the cycle after capture until DONE is left.
- CALC:
  - One multiplier bit per cycle, LSB first: if the current multiplier bit is 1, add the multiplicand shifted left by cnt into the 2*WIDTH partial product; then cnt increments.
  - After WIDTH iterations (cnt = WIDTH-1 processed), go to ACC.
  - The counter width is clog2(WIDTH)+1.
- ACC (one cycle):
  - p = neg ? (~prod + 1) : prod
  - op MUL: r = p
  - op MADD: r = acc + p
  - op MSUB: r = acc - p
  - All arithmetic is modulo 2^(2*WIDTH); there is no overflow flag.
  - Register r into result_o, set ready_o = 1, go to DONE.
- DONE:
  - result_o and ready_o hold while start_i=1.
  - When start_i=0, go to IDLE, ready_o = 0, busy_o = 0; result_o keeps its value.
  - No new capture is allowed in the cycle DONE is left.
- Latency: start sampled at edge 0 gives ready_o = 1 after edge WIDTH+1, i.e. WIDTH+2 cycles. With the EARLY_ZERO skip, ready_o = 1 after edge 1.
- Operand and accumulator inputs are ignored after capture; they may change freely.
- annul_i=1 in CALC, ACC or DONE: at the next edge go to IDLE with ready_o = 0, result_o = 0, busy_o = 0.
- annul_i=1 in IDLE: start_i is ignored that cycle.
- start_i falling in CALC or ACC without annul_i: the operation completes anyway, and DONE then exits on the next edge.
- Signed most-negative operand (0x80..0): its magnitude 2^(W-1) fits in WIDTH bits unsigned and must give the correct result.

Test Plan:
- WIDTH=32, signed MUL, -3 x 5:
  - result_o = 0xFFFFFFFF_FFFFFFF1
  - ready_o rises exactly 34 cycles after start is sampled
- Unsigned MADD, 0xFFFFFFFF x 0xFFFFFFFF, acc = 1: result_o = 0xFFFFFFFE_00000002.
- Signed MSUB, acc = 10, 2 x 3: result_o = 4.
- Signed MSUB, acc = 0, 0x80000000 x 0x80000000: result_o = 0xC0000000_00000000.
- Unsigned MADD, acc = 0xFFFFFFFF_FFFFFFFF, 1 x 1: result_o = 0 (wrap-around).
- EARLY_ZERO=1, MADD 0 x 0x1234 with acc = 7: result_o = 7 and ready_o = 1 on the second cycle.
- annul_i pulsed at CALC cycle 10:
  - busy_o = 0 and ready_o = 0 on the next cycle
  - a following MUL 6 x 7 returns 42 with full latency
- rst asserted mid-CALC: all outputs are 0 on the next cycle.
- Holding start_i in DONE for 5 cycles:
  - result stays stable and ready_o stays 1
  - dropping start_i returns the unit to IDLE in 1 cycle
